// File: rtl/rv_ctrl_pkg.sv
// Shared decode definitions for the RV32I ID stage.
// Holds the base opcode values, the ALU operation and ALU operand-A select
// encodings, the packed control bundle carried in the ID/EX register, and the
// all-zero bundle used for bubbles and illegal instructions.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_R      = 2'b10,
    ALU_I      = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    A_RS1  = 2'b00,
    A_PC   = 2'b01,
    A_ZERO = 2'b10
  } alu_a_sel_e;

  // Field order fixes the bit layout seen by EX: reg_write is the MSB,
  // alu_op occupies the two LSBs.
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       wb_pc4;
    alu_a_sel_e alu_a_sel;
    alu_op_e    alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'(12'b0);

endpackage

// File: rtl/rv_main_decoder.sv
// Combinational main decoder: maps the 7-bit opcode to the control bundle,
// an illegal flag and the register-read usage used by hazard detection.
// Ports:
//   opcode_i   in   7       instruction opcode field
//   ctrl_o     out  ctrl_t  control bundle (all zero when illegal)
//   illegal_o  out  1       opcode not recognised in this build
//   use_rs1_o  out  1       instruction reads rs1
//   use_rs2_o  out  1       instruction reads rs2
// EN_JUMP=0 turns JAL/JALR/LUI/AUIPC into illegal opcodes.
module rv_main_decoder
  import rv_ctrl_pkg::*;
#(
  parameter bit EN_JUMP = 1'b1
) (
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o,
  output logic       use_rs1_o,
  output logic       use_rs2_o
);

  // Table lookup from opcode to control bits. Everything starts at the NOP
  // bundle so unlisted fields stay zero and illegal opcodes leave ctrl empty.
  always_comb begin
    ctrl_o    = CTRL_NOP;
    illegal_o = 1'b0;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    case (opcode_i)
      OPC_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALU_R;
        use_rs1_o        = 1'b1;
        use_rs2_o        = 1'b1;
      end
      OPC_I: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_I;
        use_rs1_o        = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_op     = ALU_ADD;
        use_rs1_o         = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        use_rs1_o        = 1'b1;
        use_rs2_o        = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALU_BRANCH;
        use_rs1_o     = 1'b1;
        use_rs2_o     = 1'b1;
      end
      OPC_JAL: begin
        if (EN_JUMP) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.jump      = 1'b1;
          ctrl_o.wb_pc4    = 1'b1;
          ctrl_o.alu_a_sel = A_PC;
          ctrl_o.alu_src   = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_JALR: begin
        if (EN_JUMP) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.jump      = 1'b1;
          ctrl_o.wb_pc4    = 1'b1;
          ctrl_o.alu_src   = 1'b1;
          use_rs1_o        = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_LUI: begin
        if (EN_JUMP) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.alu_a_sel = A_ZERO;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_AUIPC: begin
        if (EN_JUMP) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.alu_a_sel = A_PC;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered ID stage of the 5-stage RV32I pipeline.
// Decodes the IF/ID instruction into the ID/EX register, inserts a single
// bubble on a load-use hazard, kills ID/EX contents on a branch flush and
// counts hazard bubbles in a saturating counter.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  IF/ID handshake; in_ready is combinational
//   instr, pc_in       instruction word and its PC
//   flush              redirect from EX, kills ID/EX contents
//   ex_ready           EX accepts ID/EX contents this cycle
//   out_valid          ID/EX holds a real instruction
//   ctrl, illegal      decoded control bundle and illegal-opcode flag
//   rs1, rs2, rd       register indices
//   funct3, funct7_5   instr[14:12], instr[30]
//   pc_out             registered PC
//   stall_cnt          load-use bubbles since reset, saturating
module rv_decode_stage
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_JUMP = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             out_valid,
  output ctrl_t            ctrl,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic             funct7_5,
  output logic [XLEN-1:0]  pc_out,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             valid_q;
  ctrl_t            ctrl_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic [2:0]       funct3_q;
  logic             funct7_5_q;
  logic [XLEN-1:0]  pc_q;
  logic             illegal_q;
  logic [CNT_W-1:0] stall_q, stall_d;

  ctrl_t decCtrl;
  logic  decIllegal, decUseRs1, decUseRs2;
  logic  advance, hazard;
  logic  unusedInstrBits;

  rv_main_decoder #(
    .EN_JUMP (EN_JUMP)
  ) u_main_decoder (
    .opcode_i  (instr[6:0]),
    .ctrl_o    (decCtrl),
    .illegal_o (decIllegal),
    .use_rs1_o (decUseRs1),
    .use_rs2_o (decUseRs2)
  );

  // Only funct7 bit 30 is carried forward; the rest of funct7 is EX's concern.
  assign unusedInstrBits = ^{instr[31], instr[29:25]};

  // The register may load when it is empty or EX is draining it. A load in
  // ID/EX whose destination the incoming instruction reads must be given a
  // bubble, because the loaded value is not available for forwarding yet.
  // x0 is never a real dependency.
  always_comb begin
    advance  = ~valid_q | ex_ready;
    hazard   = in_valid & valid_q & ctrl_q.mem_read & (rd_q != 5'd0) &
               ((decUseRs1 & (instr[19:15] == rd_q)) |
                (decUseRs2 & (instr[24:20] == rd_q)));
    in_ready = advance & ~hazard & ~flush;
    stall_d  = (&stall_q) ? stall_q : stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // ID/EX register. Flush wins over everything, even when EX is stalled,
  // so a killed instruction never reaches EX. A hazard bubble only zeroes
  // the valid/control side; index and PC fields keep their old values since
  // nothing downstream looks at them without out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7_5_q <= 1'b0;
      pc_q       <= '0;
      illegal_q  <= 1'b0;
      stall_q    <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      illegal_q <= 1'b0;
    end else if (advance) begin
      if (hazard) begin
        valid_q   <= 1'b0;
        ctrl_q    <= CTRL_NOP;
        illegal_q <= 1'b0;
        stall_q   <= stall_d;
      end else begin
        valid_q    <= in_valid;
        ctrl_q     <= decCtrl;
        illegal_q  <= decIllegal;
        rs1_q      <= instr[19:15];
        rs2_q      <= instr[24:20];
        rd_q       <= instr[11:7];
        funct3_q   <= instr[14:12];
        funct7_5_q <= instr[30];
        pc_q       <= pc_in;
      end
    end
  end

  assign out_valid = valid_q;
  assign ctrl      = ctrl_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign funct3    = funct3_q;
  assign funct7_5  = funct7_5_q;
  assign pc_out    = pc_q;
  assign illegal   = illegal_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Testbench for rv_decode_stage. Two instances share the same input stream:
// dutA is the default build, dutB has EN_JUMP=0 and a 2-bit stall counter.
// A per-instance reference model of the ID/EX register predicts each cycle;
// predictions are queued by the driver and checked by a separate monitor.
module tb_rv_decode_stage;
  import rv_ctrl_pkg::*;

  typedef enum {K_RESET, K_BUBBLE, K_LOAD} kind_e;

  typedef struct {
    bit          chk;
    bit          rdy;
    kind_e       kind;
    bit          vld;
    logic [31:0] ins;
    logic [31:0] pc;
    int          cnt;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, ex_ready;
  logic [31:0] instr, pc_in;

  logic        rdyA, vA, f7A, illA;
  ctrl_t       ctrlA;
  logic [4:0]  rs1A, rs2A, rdA;
  logic [2:0]  f3A;
  logic [31:0] pcA;
  logic [15:0] cntA;

  logic        rdyB, vB, f7B, illB;
  ctrl_t       ctrlB;
  logic [4:0]  rs1B, rs2B, rdB;
  logic [2:0]  f3B;
  logic [31:0] pcB;
  logic [1:0]  cntB;

  logic [11:0] ctrlAv, ctrlBv;
  assign ctrlAv = ctrlA;
  assign ctrlBv = ctrlB;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .EN_JUMP(1'b1), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyA), .instr(instr),
    .pc_in(pc_in), .flush(flush), .ex_ready(ex_ready), .out_valid(vA), .ctrl(ctrlA),
    .rs1(rs1A), .rs2(rs2A), .rd(rdA), .funct3(f3A), .funct7_5(f7A), .pc_out(pcA),
    .illegal(illA), .stall_cnt(cntA)
  );

  rv_decode_stage #(.XLEN(32), .EN_JUMP(1'b0), .CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyB), .instr(instr),
    .pc_in(pc_in), .flush(flush), .ex_ready(ex_ready), .out_valid(vB), .ctrl(ctrlB),
    .rs1(rs1B), .rs2(rs2B), .rd(rdB), .funct3(f3B), .funct7_5(f7B), .pc_out(pcB),
    .illegal(illB), .stall_cnt(cntB)
  );

  int    nCompared = 0;
  int    nMismatch = 0;
  snap_t qA[$];
  snap_t qB[$];

  kind_e       mKind [2];
  bit          mVld  [2];
  logic [31:0] mIns  [2];
  logic [31:0] mPc   [2];
  int          mCnt  [2];
  bit          mKnown  = 1'b0;
  bit          lastRdy = 1'b0;
  logic [31:0] pcCur   = 32'h0000_1000;
  bit          driverDone = 1'b0;

  // Expected {illegal, ctrl} straight from the decode table.
  // ctrl bit order: reg_write alu_src mem_read mem_write mem_to_reg branch jump wb_pc4 a_sel[1:0] alu_op[1:0]
  function automatic logic [12:0] refDecode(input logic [31:0] ins, input bit en);
    case (ins[6:0])
      7'b0110011: return {1'b0, 12'b1000_0000_0010};
      7'b0010011: return {1'b0, 12'b1100_0000_0011};
      7'b0000011: return {1'b0, 12'b1110_1000_0000};
      7'b0100011: return {1'b0, 12'b0101_0000_0000};
      7'b1100011: return {1'b0, 12'b0000_0100_0001};
      7'b1101111: return en ? {1'b0, 12'b1100_0011_0100} : {1'b1, 12'b0};
      7'b1100111: return en ? {1'b0, 12'b1100_0011_0000} : {1'b1, 12'b0};
      7'b0110111: return en ? {1'b0, 12'b1100_0000_1000} : {1'b1, 12'b0};
      7'b0010111: return en ? {1'b0, 12'b1100_0000_0100} : {1'b1, 12'b0};
      default:    return {1'b1, 12'b0};
    endcase
  endfunction

  // True when the instruction reads register r through rs1 or rs2.
  function automatic bit refReads(input logic [31:0] ins, input bit en, input logic [4:0] r);
    bit r1, r2;
    logic [6:0] op;
    op = ins[6:0];
    r1 = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
         (op == 7'b0100011) || (op == 7'b1100011) || (en && op == 7'b1100111);
    r2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
    return (r1 && ins[19:15] == r) || (r2 && ins[24:20] == r);
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rdd,
                                      input logic [4:0] r1, input logic [4:0] r2,
                                      input logic [2:0] f3, input logic [6:0] f7);
    return {f7, r2, r1, f3, rdd, op};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then step the model of
  // both instances and queue what each should show after the next rising edge.
  task automatic applyStimulus(input bit r, input bit iv, input logic [31:0] ins,
                               input logic [31:0] pc, input bit fl, input bit exr);
    @(negedge clk);
    rst = r; in_valid = iv; instr = ins; pc_in = pc; flush = fl; ex_ready = exr;
    for (int k = 0; k < 2; k++) begin
      bit    en, haz, adv;
      int    maxc;
      snap_t s;
      en   = (k == 0);
      maxc = (k == 0) ? 65535 : 3;
      haz  = mKnown && mVld[k] && (mKind[k] == K_LOAD) && (mIns[k][6:0] == 7'b0000011) &&
             (mIns[k][11:7] != 5'd0) && iv && refReads(ins, en, mIns[k][11:7]);
      adv  = !mVld[k] || exr;
      s.chk = mKnown;
      s.rdy = adv && !haz && !fl;
      if (r) begin
        mKind[k] = K_RESET; mVld[k] = 1'b0; mCnt[k] = 0; mIns[k] = '0; mPc[k] = '0;
      end else if (fl) begin
        mKind[k] = K_BUBBLE; mVld[k] = 1'b0;
      end else if (adv) begin
        if (haz) begin
          mKind[k] = K_BUBBLE; mVld[k] = 1'b0;
          if (mCnt[k] < maxc) mCnt[k]++;
        end else begin
          mKind[k] = K_LOAD; mVld[k] = iv; mIns[k] = ins; mPc[k] = pc;
        end
      end
      s.kind = mKind[k]; s.vld = mVld[k]; s.ins = mIns[k]; s.pc = mPc[k]; s.cnt = mCnt[k];
      if (k == 0) begin
        lastRdy = s.rdy;
        qA.push_back(s);
      end else begin
        qB.push_back(s);
      end
    end
    if (r) mKnown = 1'b1;
  endtask

  // Present an instruction until the default build accepts it.
  task automatic issue(input logic [31:0] ins);
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1'b0, 1'b1, ins, pcCur, 1'b0, 1'b1);
      if (lastRdy) break;
    end
    pcCur += 32'd4;
  endtask

  task automatic checkOutput(input string tag, input snap_t s, input logic ov,
                             input logic [11:0] c, input logic [4:0] r1, input logic [4:0] r2,
                             input logic [4:0] rdd, input logic [2:0] f3, input logic f7,
                             input logic [31:0] pc, input logic ill, input int cnt);
    logic [12:0] d;
    cmp({tag, " out_valid"}, {31'b0, ov}, {31'b0, s.vld});
    cmp({tag, " stall_cnt"}, cnt, s.cnt);
    if (s.kind == K_RESET) begin
      cmp({tag, " reset ctrl"}, {20'b0, c}, 32'b0);
      cmp({tag, " reset regs"}, {17'b0, r1, r2, rdd}, 32'b0);
      cmp({tag, " reset funct"}, {28'b0, f3, f7}, 32'b0);
      cmp({tag, " reset pc"}, pc, 32'b0);
      cmp({tag, " reset illegal"}, {31'b0, ill}, 32'b0);
    end else if (s.kind == K_BUBBLE) begin
      cmp({tag, " bubble ctrl"}, {20'b0, c}, 32'b0);
      cmp({tag, " bubble illegal"}, {31'b0, ill}, 32'b0);
    end else if (s.vld) begin
      d = refDecode(s.ins, tag == "A");
      cmp({tag, " ctrl"}, {20'b0, c}, {20'b0, d[11:0]});
      cmp({tag, " illegal"}, {31'b0, ill}, {31'b0, d[12]});
      cmp({tag, " rs1"}, {27'b0, r1}, {27'b0, s.ins[19:15]});
      cmp({tag, " rs2"}, {27'b0, r2}, {27'b0, s.ins[24:20]});
      cmp({tag, " rd"}, {27'b0, rdd}, {27'b0, s.ins[11:7]});
      cmp({tag, " funct"}, {28'b0, f3, f7}, {28'b0, s.ins[14:12], s.ins[30]});
      cmp({tag, " pc_out"}, pc, s.pc);
    end
  endtask

  // Monitor: in_ready is checked mid-cycle once inputs have settled, the
  // registered outputs just after the following rising edge.
  initial begin : monitor
    snap_t sA, sB;
    forever begin
      @(negedge clk);
      #2;
      if (qA.size() != 0 && qB.size() != 0) begin
        sA = qA.pop_front();
        sB = qB.pop_front();
        if (sA.chk) cmp("A in_ready", {31'b0, rdyA}, {31'b0, sA.rdy});
        if (sB.chk) cmp("B in_ready", {31'b0, rdyB}, {31'b0, sB.rdy});
        @(posedge clk);
        #1;
        checkOutput("A", sA, vA, ctrlAv, rs1A, rs2A, rdA, f3A, f7A, pcA, illA, int'(cntA));
        checkOutput("B", sB, vB, ctrlBv, rs1B, rs2B, rdB, f3B, f7B, pcB, illB, int'(cntB));
      end
    end
  end

  initial begin : driver
    logic [6:0]  ops [10];
    logic [31:0] ins;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    for (int k = 0; k < 2; k++) begin
      mKind[k] = K_RESET; mVld[k] = 1'b0; mIns[k] = '0; mPc[k] = '0; mCnt[k] = 0;
    end
    rst = 1'b1; in_valid = 1'b1; instr = '0; pc_in = '0; flush = 1'b0; ex_ready = 1'b1;

    $display("[TB] reset with in_valid high");
    applyStimulus(1'b1, 1'b1, enc(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0), 32'h10, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, enc(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0), 32'h10, 1'b0, 1'b1);

    $display("[TB] decode sweep");
    issue(enc(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000));
    issue(enc(7'b0010011, 5'd1, 5'd0, 5'd5, 3'd0, 7'd0));
    issue(enc(7'b0000011, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0));
    issue(enc(7'b0100011, 5'd4, 5'd2, 5'd7, 3'd2, 7'd0));
    issue(enc(7'b1100011, 5'd8, 5'd1, 5'd2, 3'd0, 7'd0));
    issue(enc(7'b1101111, 5'd1, 5'd0, 5'd16, 3'd0, 7'd0));
    issue(enc(7'b1100111, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0));
    issue(32'h1234_52B7);
    issue(32'h0000_1317);
    issue(32'h0000_007F);

    $display("[TB] load-use");
    issue(enc(7'b0000011, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0));
    issue(enc(7'b0110011, 5'd6, 5'd5, 5'd2, 3'd0, 7'd0));
    applyStimulus(1'b0, 1'b0, '0, pcCur, 1'b0, 1'b1);

    $display("[TB] no false hazard");
    issue(enc(7'b0000011, 5'd0, 5'd1, 5'd0, 3'd2, 7'd0));
    issue(enc(7'b0110011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0));
    issue(enc(7'b0000011, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0));
    issue(32'h0000_52B7);

    $display("[TB] back-pressure and flush");
    issue(enc(7'b0000011, 5'd9, 5'd1, 5'd0, 3'd2, 7'd0));
    applyStimulus(1'b0, 1'b1, enc(7'b0110011, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0), pcCur, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, enc(7'b0110011, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0), pcCur, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, enc(7'b0110011, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0), pcCur, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, pcCur, 1'b0, 1'b1);

    $display("[TB] jal in no-jump build and stall counter saturation");
    issue(enc(7'b1101111, 5'd1, 5'd0, 5'd8, 3'd0, 7'd0));
    for (int i = 0; i < 5; i++) begin
      issue(enc(7'b0000011, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0));
      issue(enc(7'b0110011, 5'd6, 5'd5, 5'd2, 3'd0, 7'd0));
    end

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      ins = enc(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 3'($urandom), 7'($urandom));
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 85), ins,
                    $urandom, ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 70));
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    driverDone = 1'b1;
  end

  // Wrap-up: give the monitor a bounded number of cycles to drain its queue.
  initial begin : finisher
    wait (driverDone);
    for (int t = 0; t < 10 && qA.size() != 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (qA.size() != 0) begin
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL drain: got %0d pending expected 0", qA.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
